// File: rtl/bp_be_dcache_wbuf_nentry.sv
// N-entry dcache write buffer: holds committed stores for the data array, forwards byte-merged
// data to younger loads, and flags snoop hits. Define BP_BE_DCACHE_WBUF_COALESCE_EN to merge same-word stores.
module bp_be_dcache_wbuf_nentry #(
  parameter int data_width_p  = 64,
  parameter int paddr_width_p = 40,
  parameter int ways_p        = 8,
  parameter int sets_p        = 64,
  parameter int els_p         = 4,
  localparam int mask_w_lp    = data_width_p / 8,
  localparam int way_w_lp     = $clog2(ways_p),
  localparam int index_w_lp   = $clog2(sets_p),
  localparam int entry_w_lp   = paddr_width_p + way_w_lp + data_width_p + mask_w_lp
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [entry_w_lp-1:0]    wbuf_entry_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [entry_w_lp-1:0]    wbuf_entry_o,
  input  logic                     yumi_i,
  output logic                     empty_o,
  output logic                     full_o,
  input  logic                     bypass_v_i,
  input  logic [paddr_width_p-1:0] bypass_addr_i,
  output logic [data_width_p-1:0]  bypass_data_o,
  output logic [mask_w_lp-1:0]     bypass_mask_o,
  output logic                     tag_hit_o,
  input  logic [index_w_lp-1:0]    lce_snoop_index_i,
  input  logic [way_w_lp-1:0]      lce_snoop_way_i,
  output logic                     lce_snoop_match_o
);

  localparam int byte_off_lp  = $clog2(mask_w_lp);
  localparam int blk_off_lp   = byte_off_lp + way_w_lp;
  localparam int word_w_lp    = paddr_width_p - byte_off_lp;
  localparam int ptr_w_lp     = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp     = $clog2(els_p + 1);
  localparam int data_lsb_lp  = mask_w_lp;
  localparam int way_lsb_lp   = data_lsb_lp + data_width_p;
  localparam int paddr_lsb_lp = way_lsb_lp + way_w_lp;

  // Entry layout, LSB first: mask, data, way_id, paddr.
  function automatic logic [word_w_lp-1:0] word_of(input logic [entry_w_lp-1:0] e);
    return e[paddr_lsb_lp+byte_off_lp +: word_w_lp];
  endfunction

  function automatic logic [index_w_lp-1:0] index_of(input logic [entry_w_lp-1:0] e);
    return e[paddr_lsb_lp+blk_off_lp +: index_w_lp];
  endfunction

  function automatic logic [way_w_lp-1:0] way_of(input logic [entry_w_lp-1:0] e);
    return e[way_lsb_lp +: way_w_lp];
  endfunction

  function automatic logic [data_width_p-1:0] overlay(input logic [data_width_p-1:0] base,
                                                      input logic [entry_w_lp-1:0]   e);
    logic [data_width_p-1:0] r;
    r = base;
    for (int b = 0; b < mask_w_lp; b++)
      if (e[b]) r[8*b +: 8] = e[data_lsb_lp+8*b +: 8];
    return r;
  endfunction

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p-1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  logic [entry_w_lp-1:0]   mem_q [els_p];
  logic [entry_w_lp-1:0]   mem_d [els_p];
  logic [ptr_w_lp-1:0]     rptr_q, rptr_d, wptr_q, wptr_d, tail_idx, scan_idx;
  logic [cnt_w_lp-1:0]     count_q, count_d;
  logic [data_width_p-1:0] bypass_data_q, bypass_data_d, hit_data;
  logic [mask_w_lp-1:0]    bypass_mask_q, bypass_mask_d, hit_mask;
  logic                    pass, deq, enq, coal, hit_any, snoop_any;
  logic [word_w_lp-1:0]    bypass_word;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^bypass_addr_i[byte_off_lp-1:0];
  assign bypass_word      = bypass_addr_i[paddr_width_p-1:byte_off_lp];

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == cnt_w_lp'(els_p));
  assign ready_o       = ~full_o;
  assign v_o           = ~empty_o | v_i;
  assign wbuf_entry_o  = empty_o ? wbuf_entry_i : mem_q[rptr_q];
  assign tail_idx      = (wptr_q == '0) ? ptr_w_lp'(els_p-1) : wptr_q - ptr_w_lp'(1);
  assign bypass_data_o = bypass_data_q;
  assign bypass_mask_o = bypass_mask_q;
  assign tag_hit_o     = bypass_v_i & hit_any;
  assign lce_snoop_match_o = snoop_any;

`ifdef BP_BE_DCACHE_WBUF_COALESCE_EN
  // Merging into an entry that leaves this cycle would lose the new bytes.
  assign coal = v_i & ~empty_o
              & (word_of(mem_q[tail_idx]) == word_of(wbuf_entry_i))
              & (way_of(mem_q[tail_idx]) == way_of(wbuf_entry_i))
              & ~((count_q == cnt_w_lp'(1)) & yumi_i);
`else
  assign coal = 1'b0;
`endif

  assign pass = empty_o & v_i & yumi_i;
  assign deq  = yumi_i & ~empty_o;
  assign enq  = v_i & ~pass & ~coal;

  always_comb begin
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (enq) begin
      mem_d[wptr_q] = wbuf_entry_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (coal) begin
      mem_d[tail_idx][data_lsb_lp +: data_width_p] =
        overlay(mem_q[tail_idx][data_lsb_lp +: data_width_p], wbuf_entry_i);
      mem_d[tail_idx][mask_w_lp-1:0] = mem_q[tail_idx][mask_w_lp-1:0] | wbuf_entry_i[mask_w_lp-1:0];
    end
    if (deq) rptr_d = ptr_inc(rptr_q);
    count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
  end

  // Walk oldest to youngest so later overlays win; the incoming store is youngest of all.
  always_comb begin
    hit_data  = '0;
    hit_mask  = '0;
    hit_any   = 1'b0;
    snoop_any = 1'b0;
    scan_idx  = rptr_q;
    for (int k = 0; k < els_p; k++) begin
      if (cnt_w_lp'(k) < count_q) begin
        if (word_of(mem_q[scan_idx]) == bypass_word) begin
          hit_any  = 1'b1;
          hit_mask = hit_mask | mem_q[scan_idx][mask_w_lp-1:0];
          hit_data = overlay(hit_data, mem_q[scan_idx]);
        end
        if ((index_of(mem_q[scan_idx]) == lce_snoop_index_i) && (way_of(mem_q[scan_idx]) == lce_snoop_way_i))
          snoop_any = 1'b1;
      end
      scan_idx = ptr_inc(scan_idx);
    end
    if (v_i) begin
      if (word_of(wbuf_entry_i) == bypass_word) begin
        hit_any  = 1'b1;
        hit_mask = hit_mask | wbuf_entry_i[mask_w_lp-1:0];
        hit_data = overlay(hit_data, wbuf_entry_i);
      end
      if ((index_of(wbuf_entry_i) == lce_snoop_index_i) && (way_of(wbuf_entry_i) == lce_snoop_way_i))
        snoop_any = 1'b1;
    end
    bypass_data_d = bypass_v_i ? hit_data : bypass_data_q;
    bypass_mask_d = bypass_v_i ? hit_mask : bypass_mask_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q       <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      bypass_data_q <= '0;
      bypass_mask_q <= '0;
    end else begin
      count_q       <= count_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      bypass_data_q <= bypass_data_d;
      bypass_mask_q <= bypass_mask_d;
    end
  end

  // Entry storage is never reset; count alone defines validity.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
